mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of wait-state cycles inserted before each response (legal 0..15).
REQ-002 Parameter DEPTH, default 512, is the number of 32-bit words in the internal array; addressed by address[8:0].
REQ-003 clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 read  input  1  read request from datapath (MAR holds address).
REQ-006 write  input  1  write request from datapath (MDR holds data).
REQ-007 address  input  32  word address from MAR.
REQ-008 data_in  input  32  write data from MDR.
REQ-009 Mdatain  output  32  read data returned to MDR input mux.
REQ-010 mem_ready  output  1  one-cycle completion pulse for read or write.
REQ-011 busy  output  1  high while a transaction is in progress (not IDLE).
REQ-012 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; encoding is free.
REQ-014 Requests are sampled only in IDLE; read/write levels in WAIT or RESP are ignored.
REQ-015 IDLE, exactly one of read/write high, address[31:9]==0: latch address[8:0], data_in and op; load wait counter with WAIT_CYCLES; go to WAIT, or straight to RESP when WAIT_CYCLES==0.
REQ-016 IDLE, read and write both high: err=1 next cycle, no array access, stay IDLE.
REQ-017 IDLE, valid strobe with address[31:9]!=0: err=1 next cycle, no array access, Mdatain unchanged, stay IDLE.
REQ-018 WAIT: counter decrements each cycle; on the edge where it reaches 0 go to RESP.
REQ-019 Read: on entry to RESP, Mdatain <= array[latched address]; Mdatain holds that value until the next completed read.
REQ-020 Write: on entry to RESP, array[latched address] <= latched data; Mdatain unchanged.
REQ-021 mem_ready is high for exactly the one cycle spent in RESP; latency from accepting edge to mem_ready high = WAIT_CYCLES+1 edges.
REQ-022 RESP always returns to IDLE on the next edge; a still-asserted strobe is accepted as a new transaction from IDLE (level-sensitive, back-to-back allowed).
REQ-023 busy = (state != IDLE); mem_ready and err are never high in the same cycle.
REQ-024 Write followed immediately by read of the same address returns the newly written data.

Reset
REQ-025 clear low forces IDLE, counter 0, Mdatain 32'h00000000, mem_ready 0, busy 0, err 0, asynchronously.
REQ-026 Reset mid-transaction aborts it: no mem_ready pulse; a write not yet in RESP is not committed.
REQ-027 Array contents are not reset; reads of never-written words are don't-care.
REQ-028 First request is accepted on the first rising edge after clear returns high.

Structure
REQ-029 State encodings, DEPTH and default WAIT_CYCLES live in the shared datapath package.
REQ-030 One sub-module, mem_array (DEPTH x 32, one write port, one registered read port), is instantiated; FSM and counter stay in mem_responder.

Verification
REQ-031 Write 32'h00000012 to address 5, WAIT_CYCLES=2 -> mem_ready exactly 3 edges after accept, busy high for 3 cycles; then read address 5 -> Mdatain=32'h00000012.
REQ-032 WAIT_CYCLES=0, write 32'h53320000 to address 0 then read 0 -> each mem_ready 1 edge after accept, Mdatain=32'h53320000.
REQ-033 read and write both high in IDLE -> err pulse 1 cycle, busy stays 0, Mdatain and array unchanged.
REQ-034 Read address 32'h00000200 -> err pulse, no mem_ready; read 32'h000001FF -> normal completion.
REQ-035 read held high for 10 cycles, WAIT_CYCLES=2 -> two completed reads, mem_ready pulses 4 edges apart.
REQ-036 clear low during WAIT of a write of 32'hDEADBEEF to address 7 -> outputs reset immediately, no mem_ready; subsequent read of 7 does not return 32'hDEADBEEF (after pre-write of 32'h00000003 there).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the wait-state memory responder: FSM state
//   encoding, operation type, array geometry, default wait-state count
//   and the address range check used when a request is accepted.
package mem_responder_pkg;

    localparam int unsigned MEM_DEPTH       = 512;
    localparam int unsigned ADDR_W          = $clog2(MEM_DEPTH);
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // A word address is usable only if every bit above the array index is 0.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr[31:ADDR_W] == '0);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Datapath-side bus of the memory responder.
//   read/write    : request strobes (level-sensitive, sampled in IDLE)
//   address       : word address from MAR
//   data_in       : write data from MDR
//   Mdatain       : read data back to the MDR input mux
//   mem_ready     : one-cycle completion pulse
//   busy          : transaction in progress
//   err           : one-cycle pulse on a rejected request
interface mem_responder_if;

    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] Mdatain;
    logic        mem_ready;
    logic        busy;
    logic        err;

    modport master (
        output read, write, address, data_in,
        input  Mdatain, mem_ready, busy, err
    );

    modport slave (
        input  read, write, address, data_in,
        output Mdatain, mem_ready, busy, err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array
//   DEPTH x 32 storage with one synchronous write port and one registered
//   read port. The read register is cleared by reset and only changes when
//   re_i is asserted, so it holds the last completed read. The storage
//   itself is never reset.
//   clock, clear : system clock, async active-low reset (read register only)
//   we_i, re_i   : write / read enable for this edge
//   addr_i       : word index shared by both ports
//   wdata_i      : write data
//   rdata_o      : registered read data
module mem_array #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rdata_q <= 32'h0000_0000;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory responder with a programmable number of wait states. A request
//   is sampled only in IDLE; it either is rejected (err pulse) or runs
//   through WAIT for WAIT_CYCLES cycles and then RESP for one cycle, where
//   mem_ready is high. The array is accessed on the edge that enters RESP.
//   clock, clear : system clock, async active-low reset
//   bus          : mem_responder_if slave (strobes, address, data, status)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for a request; strobes sampled here
//   ST_WAIT | wait-state countdown of an accepted request
//   ST_RESP | array accessed on entry; mem_ready high
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned DEPTH       = MEM_DEPTH
) (
    input  logic             clock,
    input  logic             clear,
    mem_responder_if.slave   bus
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [31:0]         data_q,  data_d;
    op_t                 op_q,    op_d;
    logic                err_q,   err_d;

    logic                acc_en;
    op_t                 acc_op;
    logic [ADDR_W-1:0]   acc_addr;
    logic [31:0]         acc_data;
    logic [31:0]         rdata;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_READ;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        err_d    = 1'b0;
        acc_en   = 1'b0;
        acc_op   = op_q;
        acc_addr = addr_q;
        acc_data = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.read && bus.write) begin
                    err_d = 1'b1;
                end else if (bus.read || bus.write) begin
                    if (!addr_in_range(bus.address)) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = bus.address[ADDR_W-1:0];
                        data_d = bus.data_in;
                        op_d   = bus.write ? OP_WRITE : OP_READ;
                        cnt_d  = WAIT_LD;
                        if (WAIT_LD == '0) begin
                            // No wait states: the accepting edge is also the
                            // RESP entry edge, so access with the live request.
                            state_d  = ST_RESP;
                            acc_en   = 1'b1;
                            acc_op   = op_d;
                            acc_addr = addr_d;
                            acc_data = data_d;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                    acc_en  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_mem_array (
        .clock   (clock),
        .clear   (clear),
        .we_i    (acc_en && (acc_op == OP_WRITE)),
        .re_i    (acc_en && (acc_op == OP_READ)),
        .addr_i  (acc_addr),
        .wdata_i (acc_data),
        .rdata_o (rdata)
    );

    assign bus.Mdatain   = rdata;
    assign bus.mem_ready = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clock;
    logic clear;

    int n_vec  = 0;
    int n_miss = 0;

    mem_responder_if if2 ();
    mem_responder_if if0 ();

    mem_responder #(.WAIT_CYCLES(2)) dut2 (
        .clock (clock),
        .clear (clear),
        .bus   (if2.slave)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .clear (clear),
        .bus   (if0.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit z, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            if0.read = r; if0.write = w; if0.address = a; if0.data_in = d;
        end else begin
            if2.read = r; if2.write = w; if2.address = a; if2.data_in = d;
        end
    endtask

    function automatic logic rdy(input bit z);
        return z ? if0.mem_ready : if2.mem_ready;
    endfunction

    function automatic logic bsy(input bit z);
        return z ? if0.busy : if2.busy;
    endfunction

    function automatic logic erq(input bit z);
        return z ? if0.err : if2.err;
    endfunction

    // One accepted transaction: lat counts edges from the accepting edge
    // (inclusive) to the edge after which mem_ready is high.
    task automatic xact(input bit z, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int bcnt);
        int errs;
        lat = 0; bcnt = 0; errs = 0;
        drive(z, !wr, wr, a, d);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (i == 0) drive(z, 1'b0, 1'b0, 32'h0, 32'h0);
            lat++;
            if (bsy(z)) bcnt++;
            if (erq(z)) errs++;
            if (rdy(z)) break;
        end
        chk("xact_no_err", errs, 0);
        @(posedge clock); #1;
    endtask

    int lat, bcnt, npulse, first_i, second_i, nrdy;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        clear = 1'b0;
        #12;
        chk("rst_mdatain", if2.Mdatain, 32'h0);
        chk("rst_ready",   if2.mem_ready, 0);
        chk("rst_busy",    if2.busy, 0);
        chk("rst_err",     if2.err, 0);
        @(negedge clock);
        clear = 1'b1;

        // write 0x12 to 5, then read back, 2 wait states
        xact(1'b0, 1'b1, 32'd5, 32'h0000_0012, lat, bcnt);
        chk("w5_latency", lat, 3);
        chk("w5_busy_cycles", bcnt, 3);
        xact(1'b0, 1'b0, 32'd5, 32'h0, lat, bcnt);
        chk("r5_latency", lat, 3);
        chk("r5_data", if2.Mdatain, 32'h0000_0012);

        // zero wait states
        xact(1'b1, 1'b1, 32'd0, 32'h5332_0000, lat, bcnt);
        chk("z_w0_latency", lat, 1);
        xact(1'b1, 1'b0, 32'd0, 32'h0, lat, bcnt);
        chk("z_r0_latency", lat, 1);
        chk("z_r0_data", if0.Mdatain, 32'h5332_0000);

        // read and write both high
        drive(1'b0, 1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        chk("both_err", if2.err, 1);
        chk("both_busy", if2.busy, 0);
        chk("both_ready", if2.mem_ready, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock); #1;
        chk("both_err_1cyc", if2.err, 0);
        chk("both_mdatain", if2.Mdatain, 32'h0000_0012);
        xact(1'b0, 1'b0, 32'd5, 32'h0, lat, bcnt);
        chk("both_array", if2.Mdatain, 32'h0000_0012);

        // out-of-range read
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        @(posedge clock); #1;
        chk("oor_rd_err", if2.err, 1);
        chk("oor_rd_busy", if2.busy, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock); #1;
        chk("oor_rd_ready", if2.mem_ready, 0);
        chk("oor_rd_mdatain", if2.Mdatain, 32'h0000_0012);

        // out-of-range write must not alias onto word 0
        xact(1'b0, 1'b1, 32'd0, 32'h0A0A_0A0A, lat, bcnt);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0BAD);
        @(posedge clock); #1;
        chk("oor_wr_err", if2.err, 1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock); #1;
        xact(1'b0, 1'b0, 32'd0, 32'h0, lat, bcnt);
        chk("oor_wr_no_alias", if2.Mdatain, 32'h0A0A_0A0A);

        // top legal address
        xact(1'b0, 1'b1, 32'h0000_01FF, 32'hCAFE_0001, lat, bcnt);
        xact(1'b0, 1'b0, 32'h0000_01FF, 32'h0, lat, bcnt);
        chk("r1ff_latency", lat, 3);
        chk("r1ff_data", if2.Mdatain, 32'hCAFE_0001);

        // read held for 10 cycles: back-to-back acceptance
        npulse = 0; first_i = -1; second_i = -1;
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("b2b_excl", if2.mem_ready & if2.err, 0);
            if (if2.mem_ready) begin
                npulse++;
                if (first_i < 0) first_i = i;
                else if (second_i < 0) second_i = i;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("b2b_pulses", npulse, 2);
        chk("b2b_first", first_i, 2);
        chk("b2b_spacing", second_i - first_i, 4);
        chk("b2b_data", if2.Mdatain, 32'h0000_0012);
        for (int i = 0; i < 10 && if2.busy; i++) begin
            @(posedge clock); #1;
        end
        chk("b2b_drain", if2.busy, 0);

        // reset during WAIT of a write
        xact(1'b0, 1'b1, 32'd7, 32'h0000_0003, lat, bcnt);
        drive(1'b0, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_in_wait", if2.busy, 1);
        #2 clear = 1'b0;
        #1;
        chk("abort_busy", if2.busy, 0);
        chk("abort_ready", if2.mem_ready, 0);
        chk("abort_mdatain", if2.Mdatain, 32'h0);
        chk("abort_err", if2.err, 0);
        nrdy = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (if2.mem_ready) nrdy++;
        end
        chk("abort_no_ready", nrdy, 0);
        @(negedge clock);
        clear = 1'b1;
        xact(1'b0, 1'b0, 32'd7, 32'h0, lat, bcnt);
        chk("abort_latency", lat, 3);
        chk("abort_not_committed", if2.Mdatain, 32'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
